// File: rtl/serial_subtractor8.sv
// Bit-serial subtractor: a - b, LSB first, one bit per clock.
// Optional signed overflow output ovf when SUB_OVERFLOW_FLAG_EN is defined.
module serial_subtractor8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
`ifdef SUB_OVERFLOW_FLAG_EN
    output logic             bo,
    output logic             ovf
`else
    output logic             bo
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             diff_bit;
    logic             accept;
    logic             last;

`ifdef SUB_OVERFLOW_FLAG_EN
    logic a_msb;
    logic b_msb;
`endif

    assign accept   = start && (state != SHIFT);
    assign last     = (state == SHIFT) && (cnt == LAST);
    assign diff_bit = sa[0] ^ sb[0] ^ br;
    assign br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign res_next = {diff_bit, res[WIDTH-1:1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        next = state;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) next = DONE;
            end
            DONE: begin
                done = 1'b1;
                next = start ? SHIFT : IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // Operand load, serial borrow chain and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            res <= '0;
            cnt <= '0;
            br  <= 1'b0;
            d   <= '0;
            bo  <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            res <= '0;
            cnt <= '0;
            br  <= 1'b0;
`ifdef SUB_OVERFLOW_FLAG_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= res_next;
            br  <= br_next;
            cnt <= cnt + CW'(1);
            if (last) begin
                d  <= res_next;
                bo <= br_next;
`ifdef SUB_OVERFLOW_FLAG_EN
                ovf <= (a_msb != b_msb) && (diff_bit != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed bench for serial_subtractor8 (WIDTH=8): vector table plus
// hand-written abort, ignored-start and back-to-back sequences.
module tb_serial_subtractor8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       bo;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic       ovf;
`endif

    int n_cmp;
    int n_bad;

    serial_subtractor8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .d     (d),
`ifdef SUB_OVERFLOW_FLAG_EN
        .bo    (bo),
        .ovf   (ovf)
`else
        .bo    (bo)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for done, counting busy cycles on the way.
    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                seen = 1'b1;
                return;
            end
        end
    endtask

    // Presents a one-cycle start pulse accepted on the next rising edge.
    task automatic pulse(input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
    endtask

    vec_t vt[9];
    int   nbusy;
    bit   seen;
    int   ndone;
    logic [7:0] held;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        rst   = 1'b1;

        vt[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vt[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vt[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vt[3] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vt[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vt[5] = '{8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0};
        vt[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vt[7] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
        vt[8] = '{8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0};

        // Reset state, with start coincident with rst
        #1;
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h01;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bo", 32'(bo), 32'd0);
`ifdef SUB_OVERFLOW_FLAG_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Vector table
        foreach (vt[i]) begin
            pulse(vt[i].a, vt[i].b);
            wait_done(nbusy, seen);
            chk($sformatf("v%0d_done", i), 32'(seen), 32'd1);
            chk($sformatf("v%0d_busy", i), 32'(nbusy), 32'd8);
            chk($sformatf("v%0d_d", i), 32'(d), 32'(vt[i].d));
            chk($sformatf("v%0d_bo", i), 32'(bo), 32'(vt[i].bo));
`ifdef SUB_OVERFLOW_FLAG_EN
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vt[i].ovf));
`endif
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 32'(done), 32'd0);
            held = d;
            a = 8'h5A;
            b = 8'hC3;
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_hold", i), 32'(d), 32'(vt[i].d));
            chk($sformatf("v%0d_holdx", i), 32'(d), 32'(held));
        end

        // Start raised on the 4th busy cycle is ignored
        pulse(8'h10, 8'h01);
        ndone = 0;
        nbusy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        @(negedge clk);
        if (busy) nbusy++;
        start = 1'b1;
        a = 8'hFF;
        b = 8'h00;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) ndone++;
        end
        chk("ign_busy", 32'(nbusy), 32'd8);
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_d", 32'(d), 32'h0F);
        chk("ign_bo", 32'(bo), 32'd0);

        // Reset on the 3rd SHIFT cycle aborts the operation
        pulse(8'h00, 8'h01);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ab_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        chk("ab_d", 32'(d), 32'd0);
        chk("ab_bo", 32'(bo), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("ab_quiet", 32'(ndone), 32'd0);
        pulse(8'h00, 8'h01);
        wait_done(nbusy, seen);
        chk("ab2_done", 32'(seen), 32'd1);
        chk("ab2_d", 32'(d), 32'hFF);
        chk("ab2_bo", 32'(bo), 32'd1);

        // Back-to-back: start accepted in the DONE cycle
        repeat (2) @(negedge clk);
        pulse(8'h09, 8'h04);
        wait_done(nbusy, seen);
        chk("bb1_done", 32'(seen), 32'd1);
        chk("bb1_busy", 32'(nbusy), 32'd8);
        chk("bb1_d", 32'(d), 32'h05);
        chk("bb1_bo", 32'(bo), 32'd0);
        start = 1'b1;
        a = 8'h04;
        b = 8'h09;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        wait_done(nbusy, seen);
        chk("bb2_done", 32'(seen), 32'd1);
        chk("bb2_busy", 32'(nbusy), 32'd8);
        chk("bb2_d", 32'(d), 32'hFB);
        chk("bb2_bo", 32'(bo), 32'd1);
        @(negedge clk);
        chk("bb2_idle", 32'(done | busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
